// File: rtl/keytap_debouncer.sv
// Step-key conditioner: two-flop synchronizer, debounce FSM with optional
// hold-to-repeat, and one-cycle press/release/repeat strobes.
// The release strobe is named key_release because "release" is a reserved
// word in SystemVerilog.
module keytap_debouncer #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int REPEAT_DELAY    = 12000000,
    parameter int REPEAT_PERIOD   = 2400000,
    parameter int REARM_CYCLES    = 2,
    parameter int CNT_W           = 24
) (
    input  logic clk24,
    input  logic n_reset,
    input  logic n_key_raw,
    input  logic repeat_en,
    output logic n_key_out,
    output logic press,
    output logic key_release,
    output logic rpt,
    output logic held
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REARM,
        RPT_WAIT,
        REL_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] REARM_LAST  = CNT_W'(REARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic             sync1;
    logic             ks;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic [CNT_W-1:0] timer_inc;
    logic             from_rpt;
    logic             from_rpt_next;
    logic             held_next;
    logic             n_key_out_next;

    // Two-flop synchronizer; idles high so reset looks like a released key
    always_ff @(posedge clk24 or negedge n_reset) begin
        if (!n_reset) begin
            sync1 <= 1'b1;
            ks    <= 1'b1;
        end else begin
            sync1 <= n_key_raw;
            ks    <= sync1;
        end
    end

    // Saturating increment of the shared timer
    always_comb begin
        timer_inc = (timer == CNT_MAX) ? timer : timer + CNT_W'(1);
    end

    // Next state, next timer value and the Mealy strobes
    always_comb begin
        state_next    = state;
        timer_next    = timer_inc;
        from_rpt_next = from_rpt;
        press         = 1'b0;
        key_release   = 1'b0;
        rpt           = 1'b0;
        case (state)
            IDLE: begin
                timer_next = '0;
                if (!ks) begin
                    state_next = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (ks) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer == DEB_LAST) begin
                    state_next    = HELD;
                    timer_next    = '0;
                    from_rpt_next = 1'b0;
                    press         = 1'b1;
                end
            end
            HELD: begin
                if (ks) begin
                    state_next    = REL_WAIT;
                    timer_next    = '0;
                    from_rpt_next = 1'b0;
                end else if (!repeat_en) begin
                    timer_next = '0;
                end else if (timer == DELAY_LAST) begin
                    state_next = REARM;
                    timer_next = '0;
                    rpt        = 1'b1;
                end
            end
            REARM: begin
                if (timer == REARM_LAST) begin
                    state_next = RPT_WAIT;
                    timer_next = '0;
                end
            end
            RPT_WAIT: begin
                if (ks) begin
                    state_next    = REL_WAIT;
                    timer_next    = '0;
                    from_rpt_next = 1'b1;
                end else if (!repeat_en) begin
                    timer_next = '0;
                end else if (timer == PERIOD_LAST) begin
                    state_next = REARM;
                    timer_next = '0;
                    rpt        = 1'b1;
                end
            end
            REL_WAIT: begin
                if (!ks) begin
                    state_next = from_rpt ? RPT_WAIT : HELD;
                    timer_next = '0;
                end else if (timer == DEB_LAST) begin
                    state_next  = IDLE;
                    timer_next  = '0;
                    key_release = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Level outputs are decoded from the upcoming state so they come straight off flops
    always_comb begin
        held_next      = (state_next inside {HELD, REARM, RPT_WAIT, REL_WAIT});
        n_key_out_next = !(state_next inside {HELD, RPT_WAIT, REL_WAIT});
    end

    // State, timer and registered level outputs
    always_ff @(posedge clk24 or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            timer     <= '0;
            from_rpt  <= 1'b0;
            held      <= 1'b0;
            n_key_out <= 1'b1;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            from_rpt  <= from_rpt_next;
            held      <= held_next;
            n_key_out <= n_key_out_next;
        end
    end

endmodule

// File: tb/tb_keytap_debouncer.sv
// Self-checking bench for keytap_debouncer: directed vector table, hand-written
// corner sequences and randomized key activity against a behavioural model.
module tb_keytap_debouncer;

    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 10;
    localparam int RC = 2;
    localparam int CW = 8;

    logic clk24     = 1'b0;
    logic n_reset   = 1'b0;
    logic n_key_raw = 1'b1;
    logic repeat_en = 1'b0;
    logic n_key_out;
    logic press;
    logic key_release;
    logic rpt;
    logic held;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic raw;
        logic en;
        int   cycles;
        int   n_press;
        int   n_rel;
        int   n_rpt;
        logic exp_held;
        logic exp_nout;
    } vec_t;

    vec_t tbl [15];

    keytap_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REARM_CYCLES   (RC),
        .CNT_W          (CW)
    ) dut (
        .clk24      (clk24),
        .n_reset    (n_reset),
        .n_key_raw  (n_key_raw),
        .repeat_en  (repeat_en),
        .n_key_out  (n_key_out),
        .press      (press),
        .key_release(key_release),
        .rpt        (rpt),
        .held       (held)
    );

    always #5 clk24 = ~clk24;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic raw, input logic en);
        @(posedge clk24);
        #2;
        n_key_raw = raw;
        repeat_en = en;
    endtask

    task automatic reset_pulse(input logic raw_after);
        @(posedge clk24);
        #3;
        n_reset = 1'b0;
        #1;
        check_output("rst_nout", n_key_out, 1);
        check_output("rst_held", held, 0);
        check_output("rst_strobes", {press, key_release, rpt}, 0);
        n_key_raw = raw_after;
        @(posedge clk24);
        #3;
        n_reset = 1'b1;
    endtask

    // Behavioural model: run lengths of the synchronized key, accepted-press flag,
    // repeat countdown and remaining re-arm gap cycles.
    bit m_r1, m_r2, m_acc, m_held_q, m_nout_q;
    bit e_press, e_rel, e_rpt, mks;
    int m_zero, m_one, m_rearm, m_cnt, m_thr;

    task automatic model_reset();
        m_r1 = 1; m_r2 = 1; m_acc = 0;
        m_zero = 0; m_one = 0; m_rearm = 0; m_cnt = 0; m_thr = RD;
        m_held_q = 0; m_nout_q = 1;
    endtask

    initial model_reset();

    always @(negedge clk24) begin : monitor
        e_press = 0; e_rel = 0; e_rpt = 0;
        if (!n_reset) model_reset();
        check_output("mdl_held", held, m_held_q);
        check_output("mdl_nout", n_key_out, m_nout_q);
        if (n_reset) begin
            mks = m_r2;
            if (!m_acc) begin
                if (!mks) begin
                    m_zero++;
                    if (m_zero == D + 1) begin
                        e_press = 1; m_acc = 1; m_zero = 0; m_one = 0;
                        m_cnt = 0; m_thr = RD; m_rearm = 0;
                    end
                end else begin
                    m_zero = 0;
                end
            end else if (m_rearm > 0) begin
                m_rearm--;
                if (m_rearm == 0) begin
                    m_thr = RP; m_cnt = 0; m_one = 0;
                end
            end else if (m_one > 0) begin
                if (mks) begin
                    m_one++;
                    if (m_one == D + 1) begin
                        e_rel = 1; m_acc = 0; m_zero = 0; m_one = 0;
                    end
                end else begin
                    m_one = 0; m_cnt = 0;
                end
            end else begin
                if (mks) m_one = 1;
                else if (repeat_en) begin
                    if (m_cnt == m_thr - 1) begin
                        e_rpt = 1; m_rearm = RC;
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    m_cnt = 0;
                end
            end
            m_held_q = m_acc;
            m_nout_q = !m_acc || (m_rearm > 0);
            m_r2 = m_r1;
            m_r1 = n_key_raw;
        end
        check_output("mdl_press", press, e_press);
        check_output("mdl_release", key_release, e_rel);
        check_output("mdl_rpt", rpt, e_rpt);
    end

    initial begin
        int cp, cr, ct, seg_len;
        logic lvl, en;

        tbl[0]  = '{1'b0, 1'b0, 40, 1, 0, 0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 15, 0, 1, 0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 60, 1, 0, 3, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 15, 0, 1, 0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 10, 0, 0, 0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1,  5, 0, 0, 0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 10, 0, 0, 0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0,  8, 0, 0, 0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 10, 0, 0, 0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0,  9, 0, 0, 0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 15, 1, 1, 0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 35, 1, 0, 1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b1,  5, 0, 0, 0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 20, 0, 0, 1, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 15, 0, 1, 0, 1'b0, 1'b1};

        repeat (3) @(posedge clk24);
        #1;
        check_output("reset_nout", n_key_out, 1);
        check_output("reset_held", held, 0);
        check_output("reset_strobes", {press, key_release, rpt}, 0);
        #2;
        n_reset = 1'b1;
        repeat (5) apply_stimulus(1'b1, 1'b0);

        // Directed vector table
        for (int v = 0; v < 15; v++) begin
            cp = 0; cr = 0; ct = 0;
            for (int c = 0; c < tbl[v].cycles; c++) begin
                apply_stimulus(tbl[v].raw, tbl[v].en);
                @(negedge clk24);
                cp += int'(press);
                cr += int'(key_release);
                ct += int'(rpt);
            end
            check_output($sformatf("vec%0d_press", v), cp, tbl[v].n_press);
            check_output($sformatf("vec%0d_release", v), cr, tbl[v].n_rel);
            check_output($sformatf("vec%0d_rpt", v), ct, tbl[v].n_rpt);
            check_output($sformatf("vec%0d_held", v), held, tbl[v].exp_held);
            check_output($sformatf("vec%0d_nout", v), n_key_out, tbl[v].exp_nout);
        end

        // Clean press latency and repeat cadence, cycle by cycle
        for (int k = 0; k <= 60; k++) begin
            apply_stimulus(1'b0, 1'b1);
            @(negedge clk24);
            check_output($sformatf("cad%0d_press", k), press, k == 10);
            check_output($sformatf("cad%0d_rpt", k), rpt, k >= 30 && (k - 30) % 12 == 0);
            check_output($sformatf("cad%0d_held", k), held, k >= 11);
            check_output($sformatf("cad%0d_nout", k), n_key_out,
                         k < 11 || (k >= 31 && (k - 31) % 12 < 2));
        end
        repeat (15) apply_stimulus(1'b1, 1'b1);

        // repeat_en dropped during the re-arm gap, then restored
        for (int k = 0; k <= 70; k++) begin
            apply_stimulus(1'b0, (k <= 30 || k >= 61));
            @(negedge clk24);
            check_output($sformatf("drop%0d_rpt", k), rpt, k == 30 || k == 70);
            check_output($sformatf("drop%0d_nout", k), n_key_out, k < 11 || k == 31 || k == 32);
        end

        // Asynchronous reset while the key is held: no release strobe afterwards
        reset_pulse(1'b1);
        cr = 0;
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(1'b1, 1'b1);
            @(negedge clk24);
            cr += int'(key_release);
        end
        check_output("post_reset_release", cr, 0);

        // Randomized key activity checked by the behavioural model
        for (int s = 0; s < 150; s++) begin
            lvl = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 3) != 0);
            seg_len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 9) : $urandom_range(10, 70);
            if ($urandom_range(0, 39) == 0) reset_pulse(lvl);
            for (int c = 0; c < seg_len; c++) begin
                if ($urandom_range(0, 15) == 0) en = ~en;
                apply_stimulus(lvl, en);
            end
        end
        repeat (20) apply_stimulus(1'b1, 1'b0);
        @(negedge clk24);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
